idli_alu_m: RTL and testbench

- Nibble-serial ALU/execute stage. Sits directly downstream of idli_decode_m and consumes its op/valid output.
- Operands arrive one 4-bit nibble per cycle, least-significant nibble first.
- Produces result nibbles one cycle after each operand nibble, plus C/Z/N flags once the word completes.
- Carries propagate across nibbles through an internal carry flop.

---
 rtl/idli_alu_m.sv | 210 +++++++++++++++++++++
 tb/tb_idli_alu_m.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_alu_m.sv
// idli_alu_m: nibble-serial ALU / execute stage.
// Operands arrive one nibble per cycle, least-significant nibble first. Each
// result nibble is registered one cycle after its operand nibble. The N/Z/C
// flags are registered when the last nibble of a word has been processed.
// Optional feature: define IDLI_ALU_OVF_EN to add the o_alu_ovf signed-overflow
// output. This output has the same update and hold timing as o_alu_flags.
module idli_alu_m #(
  parameter int WORD_NIBBLES = 4,
  parameter int OP_W         = 3
) (
  input  logic            i_alu_gck,
  input  logic            i_alu_rst,
  input  logic [OP_W-1:0] i_alu_op,
  input  logic            i_alu_op_vld,
  input  logic [3:0]      i_alu_a,
  input  logic [3:0]      i_alu_b,
  output logic [3:0]      o_alu_out,
  output logic            o_alu_out_vld,
  output logic [2:0]      o_alu_flags,
  output logic            o_alu_flags_vld,
`ifdef IDLI_ALU_OVF_EN
  output logic            o_alu_ovf,
`endif
  output logic            o_alu_err
);

  localparam int CNT_W = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3'd0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3'd1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3'd2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3'd3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3'd4);
  localparam logic [OP_W-1:0] OP_ANDN = OP_W'(3'd5);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(3'd6);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(3'd7);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [OP_W-1:0]   op_r;
  logic              carry_r;
  logic              zacc_r;

  logic              start_s, active_s, last_s, err_s;
  logic [OP_W-1:0]   op_cur_s;
  logic              is_sub_s;
  logic              c_in_s;
  logic [3:0]        b_eff_s;
  logic [4:0]        sum_s;
  logic [3:0]        res_s;
  logic              c_out_s;
  logic              zacc_nxt_s;

  logic [3:0]        out_r;
  logic              out_vld_r;
  logic [2:0]        flags_r;
  logic              flags_vld_r;
  logic              err_r;

`ifdef IDLI_ALU_OVF_EN
  logic [3:0]        low_sum_s;
  logic              ovf_s;
  logic              ovf_r;
`endif

  // State register: IDLE waits for a strobe, RUN streams the remaining nibbles.
  always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
    if (i_alu_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: a strobe in IDLE starts a word, and a strobe in RUN is a protocol error.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    start_s     = 1'b0;
    active_s    = 1'b0;
    last_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_alu_op_vld) begin
          start_s     = 1'b1;
          active_s    = 1'b1;
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_RUN: begin
        active_s = 1'b1;
        err_s    = i_alu_op_vld;
        if (cnt_r == LAST_CNT) begin
          // A following strobe is taken from IDLE, so no bubble is inserted.
          last_s      = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Per-nibble datapath: adder with an inverted B operand for subtraction, logic ops, and a one-bit shift.
  always_comb begin
    op_cur_s = start_s ? i_alu_op : op_r;
    is_sub_s = (op_cur_s == OP_SUB) || (op_cur_s == OP_CMP);
    c_in_s   = start_s ? is_sub_s : carry_r;
    b_eff_s  = is_sub_s ? ~i_alu_b : i_alu_b;
    sum_s    = {1'b0, i_alu_a} + {1'b0, b_eff_s} + {4'b0000, c_in_s};
    res_s    = 4'h0;
    c_out_s  = 1'b0;
    case (op_cur_s)
      OP_ADD, OP_SUB, OP_CMP: begin
        res_s   = sum_s[3:0];
        c_out_s = sum_s[4];
      end
      OP_AND:  res_s = i_alu_a & i_alu_b;
      OP_OR:   res_s = i_alu_a | i_alu_b;
      OP_XOR:  res_s = i_alu_a ^ i_alu_b;
      OP_ANDN: res_s = i_alu_a & ~i_alu_b;
      OP_SHL: begin
        // The carry flop holds the bit that is shifted out of the previous nibble.
        res_s   = {i_alu_a[2:0], c_in_s};
        c_out_s = i_alu_a[3];
      end
      default: begin
        res_s   = 4'h0;
        c_out_s = 1'b0;
      end
    endcase
    zacc_nxt_s = (start_s ? 1'b0 : zacc_r) | (|res_s);
  end

`ifdef IDLI_ALU_OVF_EN
  // Signed overflow: carry into bit 3 XOR carry out of bit 3, arithmetic ops only.
  always_comb begin
    low_sum_s = {1'b0, i_alu_a[2:0]} + {1'b0, b_eff_s[2:0]} + {3'b000, c_in_s};
    if ((op_cur_s == OP_ADD) || is_sub_s) begin
      ovf_s = low_sum_s[3] ^ sum_s[4];
    end else begin
      ovf_s = 1'b0;
    end
  end
`endif

  // Registered datapath state and outputs. Flags change only when a word completes.
  always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
    if (i_alu_rst) begin
      op_r        <= {OP_W{1'b0}};
      carry_r     <= 1'b0;
      zacc_r      <= 1'b0;
      out_r       <= 4'h0;
      out_vld_r   <= 1'b0;
      flags_r     <= 3'b000;
      flags_vld_r <= 1'b0;
      err_r       <= 1'b0;
`ifdef IDLI_ALU_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      if (start_s) begin
        op_r <= i_alu_op;
      end
      carry_r     <= active_s ? c_out_s : 1'b0;
      zacc_r      <= active_s ? zacc_nxt_s : 1'b0;
      out_r       <= active_s ? res_s : 4'h0;
      out_vld_r   <= active_s && (op_cur_s != OP_CMP);
      flags_vld_r <= last_s;
      err_r       <= err_s;
      if (last_s) begin
        flags_r <= {res_s[3], ~zacc_nxt_s, c_out_s};
`ifdef IDLI_ALU_OVF_EN
        ovf_r   <= ovf_s;
`endif
      end
    end
  end

  assign o_alu_out       = out_r;
  assign o_alu_out_vld   = out_vld_r;
  assign o_alu_flags     = flags_r;
  assign o_alu_flags_vld = flags_vld_r;
  assign o_alu_err       = err_r;
`ifdef IDLI_ALU_OVF_EN
  assign o_alu_ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_idli_alu_m.sv
// Testbench for idli_alu_m: directed test-plan cases plus randomized streams
// checked against a word-level reference model.
module tb_idli_alu_m;

  localparam int NIB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic       op_vld;
  logic [3:0] a, b;
  logic [3:0] alu_out;
  logic       alu_out_vld;
  logic [2:0] alu_flags;
  logic       alu_flags_vld;
  logic       alu_err;
`ifdef IDLI_ALU_OVF_EN
  logic       alu_ovf;
`endif

  idli_alu_m #(.WORD_NIBBLES(NIB), .OP_W(3)) dut (
    .i_alu_gck       (clk),
    .i_alu_rst       (rst),
    .i_alu_op        (op),
    .i_alu_op_vld    (op_vld),
    .i_alu_a         (a),
    .i_alu_b         (b),
    .o_alu_out       (alu_out),
    .o_alu_out_vld   (alu_out_vld),
    .o_alu_flags     (alu_flags),
    .o_alu_flags_vld (alu_flags_vld),
`ifdef IDLI_ALU_OVF_EN
    .o_alu_ovf       (alu_ovf),
`endif
    .o_alu_err       (alu_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Instruction program consumed by run_prog.
  int          prog_n;
  logic [2:0]  prog_op  [64];
  logic [15:0] prog_a   [64];
  logic [15:0] prog_b   [64];
  int          prog_gap [64];
  int          start_cyc[64];
  int          inj_nib;

  // Observations collected at every negedge.
  logic [3:0] obs_out  [$];
  logic [2:0] obs_flags[$];
  int         obs_fcyc [$];
  logic       obs_ovf  [$];
  int         obs_err;

  // Word-level reference: the full 16-bit result and its carry and overflow.
  function automatic void model(input logic [2:0] mop, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic c, output logic v);
    logic [16:0] s;
    r = 16'h0; c = 1'b0; v = 1'b0; s = 17'h0;
    case (mop)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[15:0]; c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      3'd1, 3'd7: begin
        r = x - y; c = (x >= y);
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x & ~y;
      3'd6: begin r = {x[14:0], 1'b0}; c = x[15]; end
      default: r = 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] obs_word(input int base);
    if (obs_out.size() >= base + 4)
      return {obs_out[base+3], obs_out[base+2], obs_out[base+1], obs_out[base]};
    else
      return 16'hxxxx;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (alu_out_vld === 1'b1) obs_out.push_back(alu_out);
    if (alu_flags_vld === 1'b1) begin
      obs_flags.push_back(alu_flags);
      obs_fcyc.push_back(cyc);
`ifdef IDLI_ALU_OVF_EN
      obs_ovf.push_back(alu_ovf);
`endif
    end
    if (alu_err === 1'b1) obs_err++;
  endtask

  task automatic clear_obs();
    obs_out.delete(); obs_flags.delete(); obs_fcyc.delete(); obs_ovf.delete();
    obs_err = 0;
  endtask

  // Drives the program with the requested idle gaps. Inputs change after each negedge sample.
  task automatic run_prog();
    clear_obs();
    for (int i = 0; i < prog_n; i++) begin
      for (int g = 0; g < prog_gap[i]; g++) begin
        tick();
        op_vld = 1'b0; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      end
      for (int n = 0; n < NIB; n++) begin
        tick();
        if (n == 0) begin
          op_vld = 1'b1; op = prog_op[i]; start_cyc[i] = cyc;
        end else if (i == 0 && n == inj_nib) begin
          op_vld = 1'b1; op = 3'd1;
        end else begin
          op_vld = 1'b0; op = 3'($urandom);
        end
        a = prog_a[i][4*n +: 4];
        b = prog_b[i][4*n +: 4];
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      op_vld = 1'b0;
    end
  endtask

  task automatic set1(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    prog_n = 1; inj_nib = -1;
    prog_op[0] = o; prog_a[0] = x; prog_b[0] = y; prog_gap[0] = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_vld = 1'b0; op = 3'd0; a = 4'h0; b = 4'h0;
    clear_obs();
    tick(); tick();
    checks++;
    if ({alu_out, alu_out_vld, alu_flags, alu_flags_vld, alu_err} !== 10'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", {alu_out, alu_out_vld, alu_flags, alu_flags_vld, alu_err});
    end
`ifdef IDLI_ALU_OVF_EN
    checks++;
    if (alu_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", alu_ovf); end
`endif
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({alu_out_vld, alu_flags_vld, alu_err, alu_flags} !== 6'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 00", {alu_out_vld, alu_flags_vld, alu_err, alu_flags});
    end
  endtask

  task automatic test_add();
    set1(3'd0, 16'h00FF, 16'h0001);
    run_prog();
    checks++;
    if (obs_word(0) !== 16'h0100 || obs_out.size() != 4) begin
      errors++; $display("FAIL add_result: got %h (n=%0d) expected 0100", obs_word(0), obs_out.size());
    end
    checks++;
    if (obs_flags.size() != 1 || obs_flags[0] !== 3'b000) begin
      errors++; $display("FAIL add_flags: got n=%0d expected one pulse with flags 000", obs_flags.size());
    end
    checks++;
    if (obs_fcyc.size() != 1 || obs_fcyc[0] != start_cyc[0] + 4) begin
      errors++; $display("FAIL add_flag_timing: got n=%0d expected one pulse 4 cycles after the strobe", obs_fcyc.size());
    end
    set1(3'd0, 16'hFFFF, 16'h0001);
    run_prog();
    checks++;
    if (obs_word(0) !== 16'h0000 || obs_flags.size() != 1 || obs_flags[0] !== 3'b011) begin
      errors++; $display("FAIL add_wrap: got %h flags n=%0d expected 0000 with flags 011", obs_word(0), obs_flags.size());
    end
  endtask

  task automatic test_sub_cmp();
    set1(3'd1, 16'h1234, 16'h1234);
    run_prog();
    checks++;
    if (obs_word(0) !== 16'h0000 || obs_flags.size() != 1 || obs_flags[0] !== 3'b011) begin
      errors++; $display("FAIL sub_equal: got %h n=%0d expected 0000 with flags 011", obs_word(0), obs_flags.size());
    end
    set1(3'd7, 16'h0001, 16'h0002);
    run_prog();
    checks++;
    if (obs_out.size() != 0) begin
      errors++; $display("FAIL cmp_no_out: got %0d nibbles expected 0", obs_out.size());
    end
    checks++;
    if (obs_flags.size() != 1 || obs_flags[0] !== 3'b100) begin
      errors++; $display("FAIL cmp_flags: got n=%0d expected one pulse with flags 100", obs_flags.size());
    end
  endtask

  task automatic test_back_to_back();
    prog_n = 2; inj_nib = -1;
    prog_op[0] = 3'd6; prog_a[0] = 16'h8001; prog_b[0] = 16'hABCD; prog_gap[0] = 1;
    prog_op[1] = 3'd4; prog_a[1] = 16'hFFFF; prog_b[1] = 16'h0F0F; prog_gap[1] = 0;
    run_prog();
    checks++;
    if (obs_word(0) !== 16'h0002 || obs_word(4) !== 16'hF0F0) begin
      errors++; $display("FAIL b2b_results: got %h %h expected 0002 F0F0", obs_word(0), obs_word(4));
    end
    checks++;
    if (obs_flags.size() != 2 || obs_flags[0] !== 3'b001 || obs_flags[1] !== 3'b100) begin
      errors++; $display("FAIL b2b_flags: got n=%0d expected 2 pulses with flags 001 then 100", obs_flags.size());
    end
    checks++;
    if (obs_fcyc.size() != 2 || obs_fcyc[1] - obs_fcyc[0] != 4) begin
      errors++; $display("FAIL b2b_spacing: got n=%0d expected flag pulses spaced 4 cycles apart", obs_fcyc.size());
    end
    checks++;
    if (alu_flags !== 3'b100) begin
      errors++; $display("FAIL flags_hold: got %b expected 100", alu_flags);
    end
  endtask

  task automatic test_err();
    set1(3'd0, 16'h1111, 16'h2222);
    inj_nib = 2;
    run_prog();
    inj_nib = -1;
    checks++;
    if (obs_word(0) !== 16'h3333 || obs_out.size() != 4) begin
      errors++; $display("FAIL err_result: got %h n=%0d expected 3333", obs_word(0), obs_out.size());
    end
    checks++;
    if (obs_err != 1) begin
      errors++; $display("FAIL err_pulse: got %0d expected 1", obs_err);
    end
    checks++;
    if (obs_flags.size() != 1 || obs_flags[0] !== 3'b000) begin
      errors++; $display("FAIL err_flags: got n=%0d expected one pulse with flags 000", obs_flags.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    tick(); op_vld = 1'b1; op = 3'd0; a = 4'h1; b = 4'h1;
    tick(); op_vld = 1'b0; a = 4'h2; b = 4'h2;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({alu_out, alu_out_vld, alu_flags, alu_flags_vld, alu_err} !== 10'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 000", {alu_out, alu_out_vld, alu_flags, alu_flags_vld, alu_err});
    end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (obs_flags.size() != 0 || alu_flags !== 3'b000 || obs_err != 0) begin
      errors++; $display("FAIL midreset_flags: got pulses=%0d flags=%b err=%0d expected 0 000 0", obs_flags.size(), alu_flags, obs_err);
    end
  endtask

`ifdef IDLI_ALU_OVF_EN
  task automatic test_ovf();
    set1(3'd0, 16'h7FFF, 16'h0001);
    run_prog();
    checks++;
    if (obs_word(0) !== 16'h8000 || obs_flags.size() != 1 || obs_flags[0] !== 3'b100 || obs_ovf[0] !== 1'b1) begin
      errors++; $display("FAIL ovf_add: got %h n=%0d expected 8000 with flags 100 and ovf 1", obs_word(0), obs_flags.size());
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0]  exp_q[$];
    logic [2:0]  exp_f[$];
    logic        exp_v[$];
    logic [15:0] r;
    logic        c, v;
    for (int rep = 0; rep < 3; rep++) begin
      exp_q.delete(); exp_f.delete(); exp_v.delete();
      prog_n = 30; inj_nib = -1;
      for (int i = 0; i < prog_n; i++) begin
        prog_op[i]  = 3'($urandom_range(0, 7));
        prog_a[i]   = 16'($urandom);
        prog_b[i]   = ($urandom_range(0, 3) == 0) ? prog_a[i] : 16'($urandom);
        prog_gap[i] = $urandom_range(0, 2);
      end
      run_prog();
      for (int i = 0; i < prog_n; i++) begin
        model(prog_op[i], prog_a[i], prog_b[i], r, c, v);
        if (prog_op[i] != 3'd7)
          for (int n = 0; n < NIB; n++) exp_q.push_back(r[4*n +: 4]);
        exp_f.push_back({r[15], (r == 16'h0000), c});
        exp_v.push_back(v);
      end
      checks++;
      if (obs_out.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_out_count: got %0d expected %0d", obs_out.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_out.size(); k++) begin
        checks++;
        if (obs_out[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand_out[%0d]: got %h expected %h", k, obs_out[k], exp_q[k]);
        end
      end
      checks++;
      if (obs_flags.size() != prog_n) begin
        errors++; $display("FAIL rand_flag_count: got %0d expected %0d", obs_flags.size(), prog_n);
      end
      for (int k = 0; k < prog_n && k < obs_flags.size(); k++) begin
        checks++;
        if (obs_flags[k] !== exp_f[k] || obs_fcyc[k] != start_cyc[k] + 4) begin
          errors++; $display("FAIL rand_flags[%0d] op %0d: got %b at cycle %0d expected %b at cycle %0d",
                             k, prog_op[k], obs_flags[k], obs_fcyc[k], exp_f[k], start_cyc[k] + 4);
        end
`ifdef IDLI_ALU_OVF_EN
        checks++;
        if (obs_ovf[k] !== exp_v[k]) begin
          errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", k, obs_ovf[k], exp_v[k]);
        end
`endif
      end
      checks++;
      if (obs_err != 0 || alu_flags !== exp_f[prog_n-1]) begin
        errors++; $display("FAIL rand_tail: got err=%0d flags=%b expected 0 %b", obs_err, alu_flags, exp_f[prog_n-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_back_to_back();
    test_err();
    test_reset_mid();
`ifdef IDLI_ALU_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
